// File: rtl/riscv_pipe_pkg.sv
// Shared pipeline package: arbiter state encoding, NOP and opcode constants.
package riscv_pipe_pkg;

    localparam int unsigned DCOUNT_W = 4;

    localparam logic [31:0] NOP = 32'h0000_0013;

    localparam logic [6:0] LW    = 7'b0000011;
    localparam logic [6:0] SW    = 7'b0100011;
    localparam logic [6:0] BEQ   = 7'b1100011;
    localparam logic [6:0] ALUop = 7'b0110011;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        BUSY_I = 3'd1,
        BUSY_D = 3'd2,
        RESP_I = 3'd3,
        RESP_D = 3'd4
    } arb_state_e;

endpackage

// File: rtl/riscv_unified_mem_arbiter_if.sv
// Bundle of fetch, data and memory handshake signals around the arbiter.
interface riscv_unified_mem_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_ready;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [DATA_W-1:0] d_rdata;
    logic              d_ready;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;

    logic              err;

    // Arbiter side
    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ack,
        output if_rdata, if_ready, d_rdata, d_ready,
               mem_req, mem_we, mem_addr, mem_wdata, err
    );

    // Pipeline + memory side
    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ack,
        input  if_rdata, if_ready, d_rdata, d_ready,
               mem_req, mem_we, mem_addr, mem_wdata, err
    );
endinterface

// File: rtl/riscv_arb_fair_counter.sv
// Saturating count of consecutive data wins taken while a fetch was waiting.
module riscv_arb_fair_counter
    import riscv_pipe_pkg::*;
#(
    parameter int unsigned MAX_DWINS = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic inc_i,
    input  logic clr_i,
    output logic at_max_o
);
    logic [DCOUNT_W-1:0] count_q, count_d;
    logic                at_max_q, at_max_d;

    // Next count: clear wins over increment, increment saturates at the limit
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i && (count_q != DCOUNT_W'(MAX_DWINS))) begin
            count_d = count_q + DCOUNT_W'(1);
        end
        at_max_d = (count_d == DCOUNT_W'(MAX_DWINS));
    end

    // Count and limit-flag registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q  <= '0;
            at_max_q <= 1'b0;
        end else begin
            count_q  <= count_d;
            at_max_q <= at_max_d;
        end
    end

    assign at_max_o = at_max_q;
endmodule

// File: rtl/riscv_unified_mem_arbiter.sv
// Arbitrates one single-port variable-latency memory between IF and MEM stages.
module riscv_unified_mem_arbiter
    import riscv_pipe_pkg::*;
#(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned MAX_DWINS = 2
) (
    input logic                        clock,
    input logic                        reset,
    riscv_unified_mem_arbiter_if.slave bus
);
    localparam logic [2:0] ST_IDLE   = IDLE;
    localparam logic [2:0] ST_BUSY_I = BUSY_I;
    localparam logic [2:0] ST_BUSY_D = BUSY_D;
    localparam logic [2:0] ST_RESP_I = RESP_I;
    localparam logic [2:0] ST_RESP_D = RESP_D;

    logic [2:0]        state_q, state_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              if_ready_q, if_ready_d;
    logic              d_ready_q, d_ready_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic              err_q, err_d;
    logic              cnt_inc, cnt_clr, dwin_at_max;

    riscv_arb_fair_counter #(.MAX_DWINS(MAX_DWINS)) u_fair (
        .clock    (clock),
        .reset    (reset),
        .inc_i    (cnt_inc),
        .clr_i    (cnt_clr),
        .at_max_o (dwin_at_max)
    );

    // Next-state, datapath and error logic
    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_ready_d  = 1'b0;
        d_ready_d   = 1'b0;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
        err_d       = err_q;
        cnt_inc     = 1'b0;
        cnt_clr     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.mem_ack) err_d = 1'b1;
                if (bus.d_req && (!bus.if_req || !dwin_at_max)) begin
                    state_d     = ST_BUSY_D;
                    mem_req_d   = 1'b1;
                    mem_we_d    = bus.d_we;
                    mem_addr_d  = bus.d_addr;
                    mem_wdata_d = bus.d_wdata;
                    cnt_inc     = bus.if_req;
                    cnt_clr     = !bus.if_req;
                end else if (bus.if_req) begin
                    state_d    = ST_BUSY_I;
                    mem_req_d  = 1'b1;
                    mem_we_d   = 1'b0;
                    mem_addr_d = bus.if_addr;
                    cnt_clr    = 1'b1;
                end
            end
            ST_BUSY_I: begin
                if (!bus.if_req) err_d = 1'b1;
                if (bus.mem_ack) begin
                    if_rdata_d = bus.mem_rdata;
                    mem_req_d  = 1'b0;
                    mem_we_d   = 1'b0;
                    if_ready_d = 1'b1;
                    state_d    = ST_RESP_I;
                end
            end
            ST_BUSY_D: begin
                if (!bus.d_req) err_d = 1'b1;
                if (bus.mem_ack) begin
                    if (!mem_we_q) d_rdata_d = bus.mem_rdata;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    d_ready_d = 1'b1;
                    state_d   = ST_RESP_D;
                end
            end
            ST_RESP_I, ST_RESP_D: begin
                if (bus.mem_ack) err_d = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_ready_q  <= 1'b0;
            d_ready_q   <= 1'b0;
            if_rdata_q  <= DATA_W'(NOP);
            d_rdata_q   <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_ready_q  <= if_ready_d;
            d_ready_q   <= d_ready_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
            err_q       <= err_d;
        end
    end

    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.if_ready  = if_ready_q;
    assign bus.d_ready   = d_ready_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.err       = err_q;
endmodule

// File: tb/tb_riscv_unified_mem_arbiter.sv
// Self-checking bench: memory responder, reference memory model and scenario tasks.
module tb_riscv_unified_mem_arbiter;
    import riscv_pipe_pkg::*;

    localparam int unsigned AW   = 32;
    localparam int unsigned DW   = 32;
    localparam int unsigned MAXW = 2;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    riscv_unified_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    riscv_unified_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_DWINS(MAXW)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Memory responder: acks L cycles after mem_req rises
    bit   [31:0] resp_mem [256];
    logic        resp_ack = 1'b0;
    logic        man_ack  = 1'b0;
    logic [31:0] resp_rdata = '0;
    int          rcnt = 0;
    int          lat = 1;
    bit          pre_en = 1'b0;
    logic [7:0]  pre_idx = '0;
    logic [31:0] pre_data = '0;

    assign bus.mem_ack   = resp_ack | man_ack;
    assign bus.mem_rdata = resp_rdata;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            rcnt     <= 0;
            resp_ack <= 1'b0;
        end else begin
            resp_ack <= 1'b0;
            if (pre_en) resp_mem[pre_idx] <= pre_data;
            if (bus.mem_req && !resp_ack) begin
                if (rcnt + 1 >= lat) begin
                    resp_ack   <= 1'b1;
                    resp_rdata <= resp_mem[bus.mem_addr[9:2]];
                    if (bus.mem_we) resp_mem[bus.mem_addr[9:2]] <= bus.mem_wdata;
                    rcnt <= 0;
                end else begin
                    rcnt <= rcnt + 1;
                end
            end else begin
                rcnt <= 0;
            end
        end
    end

    // Bus monitor: grant log and activity counters
    logic [32:0] grants [$];
    logic        req_prev = 1'b0;
    int          req_cycles = 0, we_cycles = 0, we_out = 0, ifr_cnt = 0, dr_cnt = 0;

    always @(negedge clock) begin
        req_prev <= bus.mem_req;
        if (bus.mem_req && !req_prev) grants.push_back({bus.mem_we, bus.mem_addr});
        if (bus.mem_req) req_cycles <= req_cycles + 1;
        if (bus.mem_we && bus.mem_req) we_cycles <= we_cycles + 1;
        if (bus.mem_we && !bus.mem_req) we_out <= we_out + 1;
        if (bus.if_ready) ifr_cnt <= ifr_cnt + 1;
        if (bus.d_ready) dr_cnt <= dr_cnt + 1;
    end

    // Reference model state
    bit   [31:0] ref_mem [256];
    logic [31:0] exp_drdata = '0;

    bit to_d, to_i;

    task automatic preload(input logic [31:0] addr, input logic [31:0] data);
        @(posedge clock); #1;
        pre_en = 1'b1; pre_idx = addr[9:2]; pre_data = data;
        ref_mem[addr[9:2]] = data;
        @(posedge clock); #1;
        pre_en = 1'b0;
    endtask

    // One transaction; returns request-to-ready cycles, returned data, other-port pulse, timeout
    task automatic run_req(input bit is_d, input bit we, input logic [31:0] addr,
                           input logic [31:0] wdata, output int cyc, output logic [31:0] data,
                           output bit other, output bit to);
        int base_other;
        @(posedge clock); #1;
        base_other = is_d ? ifr_cnt : dr_cnt;
        if (is_d) begin
            bus.d_req = 1'b1; bus.d_we = we; bus.d_addr = addr; bus.d_wdata = wdata;
        end else begin
            bus.if_req = 1'b1; bus.if_addr = addr;
        end
        cyc = 0; to = 1'b1; data = '0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clock);
            if ((is_d ? bus.d_ready : bus.if_ready) === 1'b1) begin
                to = 1'b0;
                data = is_d ? bus.d_rdata : bus.if_rdata;
                break;
            end
            cyc++;
        end
        @(posedge clock); #1;
        if (is_d) bus.d_req = 1'b0; else bus.if_req = 1'b0;
        other = ((is_d ? ifr_cnt : dr_cnt) != base_other);
    endtask

    // Continuous requester: presents the next request on the edge after each ready
    task automatic req_stream(input bit is_d, input int n, input logic [31:0] base, output bit to);
        bit seen;
        to = 1'b0;
        @(posedge clock); #1;
        for (int k = 0; k < n; k++) begin
            if (is_d) begin
                bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = base + 32'(4 * k); bus.d_wdata = '0;
            end else begin
                bus.if_req = 1'b1; bus.if_addr = base + 32'(4 * k);
            end
            seen = 1'b0;
            for (int i = 0; i < 100; i++) begin
                @(negedge clock);
                if ((is_d ? bus.d_ready : bus.if_ready) === 1'b1) begin
                    seen = 1'b1;
                    break;
                end
            end
            if (!seen) to = 1'b1;
            @(posedge clock); #1;
        end
        if (is_d) bus.d_req = 1'b0; else bus.if_req = 1'b0;
    endtask

    task automatic test_reset();
        bus.if_req = 1'b0; bus.if_addr = '0;
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
        reset = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        n_checks++;
        if ({bus.mem_req, bus.mem_we, bus.if_ready, bus.d_ready, bus.err} !== 5'b0)
            $display("FAIL reset_ctrl: got %b want 00000", {bus.mem_req, bus.mem_we, bus.if_ready, bus.d_ready, bus.err});
        else n_pass++;
        n_checks++;
        if ({bus.mem_addr, bus.mem_wdata} !== 64'h0)
            $display("FAIL reset_mem_bus: got %h want 0", {bus.mem_addr, bus.mem_wdata});
        else n_pass++;
        n_checks++;
        if (bus.if_rdata !== 32'h0000_0013) $display("FAIL reset_if_rdata: got %h want 00000013", bus.if_rdata);
        else n_pass++;
        n_checks++;
        if (bus.d_rdata !== 32'h0) $display("FAIL reset_d_rdata: got %h want 0", bus.d_rdata);
        else n_pass++;
        reset = 1'b0;
    endtask

    task automatic test_lone_fetch();
        int cyc, bg, brc;
        logic [31:0] data;
        bit other, to;
        preload(32'h10, 32'h00A0_0093);
        lat = 1;
        bg = grants.size(); brc = req_cycles;
        run_req(1'b0, 1'b0, 32'h10, 32'h0, cyc, data, other, to);
        n_checks++;
        if (to || cyc != 3) $display("FAIL fetch_latency: got %0d (timeout %0d) want 3", cyc, to);
        else n_pass++;
        n_checks++;
        if (data !== 32'h00A0_0093) $display("FAIL fetch_data: got %h want 00a00093", data);
        else n_pass++;
        n_checks++;
        if (other) $display("FAIL fetch_no_d_ready: got d_ready pulse want none");
        else n_pass++;
        n_checks++;
        if (grants.size() != bg + 1 || grants[bg] !== {1'b0, 32'h10})
            $display("FAIL fetch_grant: got %0d grants want 1 to addr 10", grants.size() - bg);
        else n_pass++;
        n_checks++;
        if (req_cycles - brc != 2) $display("FAIL fetch_req_cycles: got %0d want 2", req_cycles - brc);
        else n_pass++;
        @(negedge clock);
        n_checks++;
        if (bus.if_rdata !== 32'h00A0_0093) $display("FAIL fetch_hold: got %h want 00a00093", bus.if_rdata);
        else n_pass++;
    endtask

    task automatic test_store_load();
        int cyc, bg, bwe, bwo;
        logic [31:0] data;
        bit other, to;
        lat = 3;
        bg = grants.size(); bwe = we_cycles; bwo = we_out;
        run_req(1'b1, 1'b1, 32'h40, 32'hDEAD_BEEF, cyc, data, other, to);
        ref_mem[6'h10] = 32'hDEAD_BEEF;
        n_checks++;
        if (to || cyc != 5) $display("FAIL store_latency: got %0d (timeout %0d) want 5", cyc, to);
        else n_pass++;
        n_checks++;
        if (data !== exp_drdata) $display("FAIL store_keeps_rdata: got %h want %h", data, exp_drdata);
        else n_pass++;
        run_req(1'b1, 1'b0, 32'h40, 32'h0, cyc, data, other, to);
        exp_drdata = ref_mem[6'h10];
        n_checks++;
        if (to || data !== 32'hDEAD_BEEF) $display("FAIL load_data: got %h want deadbeef", data);
        else n_pass++;
        n_checks++;
        if (grants.size() != bg + 2 || grants[bg] !== {1'b1, 32'h40} || grants[bg + 1] !== {1'b0, 32'h40})
            $display("FAIL store_load_grants: got %0d grants want store then load at 40", grants.size() - bg);
        else n_pass++;
        n_checks++;
        if (we_cycles - bwe != 4 || we_out != bwo)
            $display("FAIL mem_we_window: got %0d/%0d want 4/0", we_cycles - bwe, we_out - bwo);
        else n_pass++;
    endtask

    task automatic test_contention();
        int bg, pd, pi, wins;
        bit exp_d, got_d;
        lat = 2;
        bg = grants.size();
        fork
            req_stream(1'b1, 4, 32'h1000, to_d);
            req_stream(1'b0, 2, 32'h2000, to_i);
        join
        n_checks++;
        if (to_d || to_i || grants.size() != bg + 6)
            $display("FAIL contention_count: got %0d grants (timeouts %0d %0d) want 6", grants.size() - bg, to_d, to_i);
        else n_pass++;
        pd = 4; pi = 2; wins = 0;
        for (int g = 0; g < 6; g++) begin
            if (pd > 0 && (pi == 0 || wins < int'(MAXW))) begin
                exp_d = 1'b1; wins = (pi > 0) ? wins + 1 : 0; pd--;
            end else begin
                exp_d = 1'b0; wins = 0; pi--;
            end
            got_d = (grants.size() > bg + g) ? (grants[bg + g][31:0] < 32'h2000) : ~exp_d;
            n_checks++;
            if (got_d !== exp_d) $display("FAIL contention_order[%0d]: got D=%0d want D=%0d", g, got_d, exp_d);
            else n_pass++;
        end
        n_checks++;
        if (bus.err !== 1'b0) $display("FAIL contention_err: got %b want 0", bus.err);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int cyc, bg, l;
        logic [31:0] data, addr, wdata, expv;
        bit other, to, is_d, we;
        for (int t = 0; t < 12; t++) begin
            is_d  = 1'($urandom_range(0, 1));
            we    = is_d ? 1'($urandom_range(0, 1)) : 1'b0;
            addr  = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
            wdata = $urandom;
            l     = $urandom_range(1, 4);
            lat   = l;
            bg    = grants.size();
            run_req(is_d, we, addr, wdata, cyc, data, other, to);
            if (is_d && we) begin
                expv = exp_drdata;
                ref_mem[addr[9:2]] = wdata;
            end else begin
                expv = ref_mem[addr[9:2]];
                if (is_d) exp_drdata = expv;
            end
            n_checks++;
            if (to || cyc != l + 2) $display("FAIL b2b_latency[%0d]: got %0d want %0d", t, cyc, l + 2);
            else n_pass++;
            n_checks++;
            if (data !== expv) $display("FAIL b2b_data[%0d]: got %h want %h", t, data, expv);
            else n_pass++;
            repeat (3) @(posedge clock);
            n_checks++;
            if (grants.size() != bg + 1 || other)
                $display("FAIL b2b_single_grant[%0d]: got %0d grants (other ready %0d) want 1", t, grants.size() - bg, other);
            else n_pass++;
        end
    endtask

    task automatic test_spurious_ack();
        int bg, bi, bd, cyc;
        logic [31:0] data;
        bit other, to;
        bg = grants.size(); bi = ifr_cnt; bd = dr_cnt;
        @(posedge clock); #1; man_ack = 1'b1;
        @(posedge clock); #1; man_ack = 1'b0;
        @(negedge clock);
        n_checks++;
        if (bus.err !== 1'b1) $display("FAIL spurious_err: got %b want 1", bus.err);
        else n_pass++;
        repeat (3) @(negedge clock);
        n_checks++;
        if (bus.err !== 1'b1 || bus.mem_req !== 1'b0 || grants.size() != bg || ifr_cnt != bi || dr_cnt != bd)
            $display("FAIL spurious_quiet: got err=%b mem_req=%b grants=%0d want err=1 and no activity",
                     bus.err, bus.mem_req, grants.size() - bg);
        else n_pass++;
        lat = 2;
        run_req(1'b0, 1'b0, 32'h10, 32'h0, cyc, data, other, to);
        n_checks++;
        if (to || cyc != 4 || data !== ref_mem[4] || bus.err !== 1'b1)
            $display("FAIL spurious_then_fetch: got cyc=%0d data=%h err=%b want 4 %h 1", cyc, data, bus.err, ref_mem[4]);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        int bd, cyc;
        logic [31:0] data;
        bit other, to;
        lat = 5;
        @(posedge clock); #1;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h40;
        repeat (3) @(negedge clock);
        n_checks++;
        if (bus.mem_req !== 1'b1) $display("FAIL mid_busy: got mem_req=%b want 1", bus.mem_req);
        else n_pass++;
        #1 reset = 1'b1;
        #1;
        n_checks++;
        if (bus.mem_req !== 1'b0 || bus.d_ready !== 1'b0 || bus.err !== 1'b0)
            $display("FAIL mid_reset_async: got req=%b rdy=%b err=%b want 0 0 0", bus.mem_req, bus.d_ready, bus.err);
        else n_pass++;
        bus.d_req = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock); reset = 1'b0;
        bd = dr_cnt;
        repeat (8) @(negedge clock);
        n_checks++;
        if (dr_cnt != bd || bus.mem_req !== 1'b0) $display("FAIL mid_abandoned: got %0d d_ready pulses want 0", dr_cnt - bd);
        else n_pass++;
        @(posedge clock); #1; man_ack = 1'b1;
        @(posedge clock); #1; man_ack = 1'b0;
        @(negedge clock);
        n_checks++;
        if (bus.err !== 1'b1) $display("FAIL late_ack_err: got %b want 1", bus.err);
        else n_pass++;
        lat = 2;
        run_req(1'b0, 1'b0, 32'h10, 32'h0, cyc, data, other, to);
        n_checks++;
        if (to || cyc != 4 || data !== ref_mem[4])
            $display("FAIL mid_recover_fetch: got cyc=%0d data=%h want 4 %h", cyc, data, ref_mem[4]);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_lone_fetch();
        test_store_load();
        test_contention();
        test_back_to_back();
        test_spurious_ack();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no completion want finish before time limit");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/riscv_unified_mem_arbiter.md
Name: riscv_unified_mem_arbiter

Overview:
- Shares one single-port, variable-latency unified memory between the 5-stage pipeline's IF stage (instruction fetch) and MEM stage (LW/SW data access).
- Replaces the split IMemory/DMemory arrangement.
- Pipeline stalls on a port until that port's ready pulse.
- Data port has priority, since it serves the older instruction. A fairness counter bounds IF starvation.

Parameters:
ADDR_W, 32, byte-address width on all address ports
DATA_W, 32, data width on all data ports
MAX_DWINS, 2, consecutive data grants allowed while if_req waits before IF is forced; range 1..15

Ports:
clock  in  1  single rising-edge clock
reset  in  1  asynchronous, active-high reset
if_req  in  1  fetch request; held with if_addr stable until if_ready
if_addr  in  ADDR_W  fetch address (PC)
if_rdata  out  DATA_W  fetched instruction; valid while if_ready=1, held after
if_ready  out  1  one-cycle completion pulse for fetch
d_req  in  1  data request; held with d_we/d_addr/d_wdata stable until d_ready
d_we  in  1  1=store (SW), 0=load (LW)
d_addr  in  ADDR_W  data address (EXMEMALUOut)
d_wdata  in  DATA_W  store data (EXMEMB)
d_rdata  out  DATA_W  load data; valid while d_ready=1, held after
d_ready  out  1  one-cycle completion pulse for data
mem_req  out  1  memory request; held until mem_ack
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  memory byte address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data; valid when mem_ack=1
mem_ack  in  1  one-cycle completion from memory, earliest one cycle after mem_req rises
err  out  1  sticky protocol-error flag

Behaviour:
- Reset values (async, immediate): state=IDLE; mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0; if_ready=0, d_ready=0; if_rdata=NOP (32'h0000_0013); d_rdata=0; dcount=0; err=0. All outputs are registered.
- FSM states:
  - IDLE: arbitrate among sampled requests.
  - BUSY_I, BUSY_D: mem_req=1; wait for mem_ack.
  - RESP_I, RESP_D: ready=1 for exactly one cycle; no arbitration.
  - RESP then goes to IDLE, so a requester dropping req on the edge after ready is never re-granted.
- Arbitration in IDLE:
  - d_req only -> BUSY_D.
  - if_req only -> BUSY_I.
  - Both, dcount<MAX_DWINS -> BUSY_D, dcount++.
  - Both, dcount==MAX_DWINS -> BUSY_I.
  - Any IF grant, or a D grant with if_req=0 -> dcount=0.
  - Neither -> stay IDLE.
- On entering BUSY_x: mem_addr, mem_we and mem_wdata load from the winner on the same edge that mem_req rises. They stay stable until the ack edge.
- mem_ack in BUSY_I: if_rdata<=mem_rdata, mem_req<=0, go to RESP_I (if_ready=1).
- mem_ack in BUSY_D:
  - Read: d_rdata<=mem_rdata.
  - Write: d_rdata unchanged.
  - Then mem_req<=0, go to RESP_D (d_ready=1).
- Latency: from req sampled in IDLE, ready is asserted L+2 cycles later, where L≥1 is memory cycles from mem_req to mem_ack. Minimum request-to-ready is 3 cycles.
- Protocol errors set err sticky (cleared only by reset):
  - mem_ack while not in BUSY_x; the ack is otherwise ignored.
  - Requester dropping req while its grant is in BUSY_x; the transaction still completes and its ready still pulses.
- Reset mid-transaction: the in-flight access is abandoned. mem_req falls asynchronously. A late mem_ack after reset release is flagged as err=1.
- Width rules: addresses pass through unmodified, with no shift inside the block. Word alignment is the memory's concern.

Decomposition:
- Shared package riscv_pipe_pkg:
  - arbiter state enum (IDLE, BUSY_I, BUSY_D, RESP_I, RESP_D)
  - NOP constant 32'h0000_0013
  - opcode constants LW, SW, BEQ, ALUop
- One natural sub-module, riscv_arb_fair_counter: saturating dcount with inc/clr inputs and an at_max output.
- FSM and datapath registers stay in the top module.

Test Plan:
- Lone fetch: if_req=1, if_addr=0x10, memory returns 0x00A00093 with L=1 -> mem_req high cycles 1–2; if_ready pulses at cycle 3 with if_rdata=0x00A00093; d_ready stays 0.
- Store then load, L=3: SW d_addr=0x40 d_wdata=0xDEADBEEF, then LW 0x40 -> mem_we=1 only during the store; load d_rdata=0xDEADBEEF; d_rdata not changed by the store's ack.
- Contention, MAX_DWINS=2, both requesters continuously requesting -> grant order D,D,I,D,D,I; dcount resets after each I grant.
- Back-to-back handshake: requester drops if_req on the edge after if_ready -> exactly one mem_req burst; no duplicate grant.
- Spurious mem_ack in IDLE -> err=1 and stays 1; no ready pulse; no state change.
- Reset asserted mid BUSY_D with L=5 -> mem_req=0 and d_ready=0 immediately; after release the FSM is in IDLE and a new if_req completes normally.
